// File: rtl/post_addsub_acc_if.sv
// Interface bundling the data/handshake signals of post_addsub_acc.
// The master drives the operands. The slave (the post-adder) returns P, cout and out_valid.
// The POST_ADDSUB_OVF_EN macro adds the sticky signed-overflow flag ovf.
interface post_addsub_acc_if #(
  parameter int WIDTH = 48
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             add_subb;
  logic             acc_en;
  logic             acc_clr;
  logic             out_valid;
  logic [WIDTH-1:0] P;
  logic             cout;
`ifdef POST_ADDSUB_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, add_subb, acc_en, acc_clr,
    input  out_valid, P, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, add_subb, acc_en, acc_clr,
    output out_valid, P, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, add_subb, acc_en, acc_clr,
    input  out_valid, P, cout
  );
  modport slave (
    input  in_valid, a, b, cin, add_subb, acc_en, acc_clr,
    output out_valid, P, cout
  );
`endif
endinterface

// File: rtl/post_addsub_acc.sv
// Pipelined post-adder/subtracter with accumulator feedback and carry-out.
// Stage 1 is an optional input register (PIPE_IN). Stage 2 selects Z, adds or subtracts,
// and registers P, cout and out_valid.
// The POST_ADDSUB_OVF_EN macro adds a sticky signed-overflow flag (bus.ovf).
// That flag is cleared by reset or by an acc_clr sample.
module post_addsub_acc #(
  parameter int WIDTH   = 48,
  parameter int PIPE_IN = 1
) (
  input  logic              CLK,
  input  logic              RSTP,
  input  logic              CE,
  post_addsub_acc_if.slave  bus
);

  // Stage-1 view of the sample, either registered or straight from the bus
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_cin;
  logic             s1_sub;
  logic             s1_en;
  logic             s1_clr;

  generate
    if (PIPE_IN != 0) begin : g_in_reg
      logic             valid_q;
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic             cin_q;
      logic             sub_q;
      logic             en_q;
      logic             clr_q;

      // Input register stage. Reset drops any in-flight sample.
      always_ff @(posedge CLK) begin
        if (RSTP) begin
          valid_q <= 1'b0;
          a_q     <= '0;
          b_q     <= '0;
          cin_q   <= 1'b0;
          sub_q   <= 1'b0;
          en_q    <= 1'b0;
          clr_q   <= 1'b0;
        end else if (CE) begin
          valid_q <= bus.in_valid;
          a_q     <= bus.a;
          b_q     <= bus.b;
          cin_q   <= bus.cin;
          sub_q   <= bus.add_subb;
          en_q    <= bus.acc_en;
          clr_q   <= bus.acc_clr;
        end
      end

      assign s1_valid = valid_q;
      assign s1_a     = a_q;
      assign s1_b     = b_q;
      assign s1_cin   = cin_q;
      assign s1_sub   = sub_q;
      assign s1_en    = en_q;
      assign s1_clr   = clr_q;
    end else begin : g_in_wire
      assign s1_valid = bus.in_valid;
      assign s1_a     = bus.a;
      assign s1_b     = bus.b;
      assign s1_cin   = bus.cin;
      assign s1_sub   = bus.add_subb;
      assign s1_en    = bus.acc_en;
      assign s1_clr   = bus.acc_clr;
    end
  endgenerate

  logic [WIDTH-1:0] p_q;
  logic             cout_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] z_d;
  logic [WIDTH:0]   r_d;

  // Stage-2 arithmetic: choose Z (clear > feedback > b), then a (WIDTH+1)-bit add/sub
  always_comb begin
    z_d = s1_clr ? '0 : (s1_en ? p_q : s1_b);
    if (s1_sub) begin
      r_d = {1'b0, z_d} - {1'b0, s1_a} - {{WIDTH{1'b0}}, s1_cin};
    end else begin
      r_d = {1'b0, z_d} + {1'b0, s1_a} + {{WIDTH{1'b0}}, s1_cin};
    end
  end

  // Result register. An invalid clear sample still zeroes the accumulator.
  always_ff @(posedge CLK) begin
    if (RSTP) begin
      p_q         <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (CE) begin
      if (s1_valid) begin
        p_q         <= r_d[WIDTH-1:0];
        cout_q      <= r_d[WIDTH];
        out_valid_q <= 1'b1;
      end else begin
        if (s1_clr) begin
          p_q    <= '0;
          cout_q <= 1'b0;
        end
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.P         = p_q;
  assign bus.cout      = cout_q;
  assign bus.out_valid = out_valid_q;

`ifdef POST_ADDSUB_OVF_EN
  logic ovf_q;
  logic sign_a_d;
  logic ovf_now_d;

  // Signed overflow: the result sign differs from both effective operand signs
  always_comb begin
    sign_a_d  = s1_sub ? ~s1_a[WIDTH-1] : s1_a[WIDTH-1];
    ovf_now_d = (z_d[WIDTH-1] ^ r_d[WIDTH-1]) & (sign_a_d ^ r_d[WIDTH-1]);
  end

  // Sticky overflow flag. A clear sample restarts it from this sample's result.
  always_ff @(posedge CLK) begin
    if (RSTP) begin
      ovf_q <= 1'b0;
    end else if (CE) begin
      if (s1_clr) begin
        ovf_q <= s1_valid & ovf_now_d;
      end else if (s1_valid) begin
        ovf_q <= ovf_q | ovf_now_d;
      end
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_post_addsub_acc.sv
// Scoreboard bench for post_addsub_acc (WIDTH=48, PIPE_IN=1, default build).
// The driver runs a sample-order reference model and queues each expected result.
// Each entry is tagged with the CE-edge count at which it must appear.
// The monitor checks every edge: a popped result, an empty output, a frozen hold or a reset.
module tb_post_addsub_acc;
  localparam int W = 48;

  logic clk = 1'b0;
  logic rstp;
  logic ce;

  post_addsub_acc_if #(.WIDTH(W)) bus ();

  post_addsub_acc #(.WIDTH(W), .PIPE_IN(1)) dut (
    .CLK  (clk),
    .RSTP (rstp),
    .CE   (ce),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] p;
    logic         cout;
    int           cnt;
  } exp_t;

  exp_t         q[$];
  int           n_chk  = 0;
  int           n_fail = 0;
  int           ce_cnt = 0;
  bit           started = 1'b0;
  bit           last_rst = 1'b1;
  bit           last_ce  = 1'b0;
  logic [W-1:0] model_p = '0;
  logic [W-1:0] prev_p;
  logic         prev_cout;
  logic         prev_ov;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Edge bookkeeping: which kind of edge just happened and how many CE edges so far
  always @(posedge clk) begin
    started  = 1'b1;
    last_rst = rstp;
    last_ce  = ce;
    if (!rstp && ce) ce_cnt++;
  end

  // Monitor: classify the edge just taken and check the outputs accordingly
  always @(negedge clk) begin
    if (started) begin
      if (last_rst) begin
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_P", {16'd0, bus.P}, 64'd0);
        chk("rst_cout", {63'd0, bus.cout}, 64'd0);
      end else if (!last_ce) begin
        chk("hold_out_valid", {63'd0, bus.out_valid}, {63'd0, prev_ov});
        chk("hold_P", {16'd0, bus.P}, {16'd0, prev_p});
        chk("hold_cout", {63'd0, bus.cout}, {63'd0, prev_cout});
      end else if (q.size() > 0 && q[0].cnt == ce_cnt) begin
        exp_t e;
        e = q.pop_front();
        chk("out_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("P", {16'd0, bus.P}, {16'd0, e.p});
        chk("cout", {63'd0, bus.cout}, {63'd0, e.cout});
        $display("out #%0d P=%012h cout=%0b (exp P=%012h cout=%0b)",
                 ce_cnt, bus.P, bus.cout, e.p, e.cout);
      end else begin
        chk("idle_out_valid", {63'd0, bus.out_valid}, 64'd0);
      end
    end
    prev_p    = bus.P;
    prev_cout = bus.cout;
    prev_ov   = bus.out_valid;
  end

  // Drive one cycle of stimulus and advance the reference model in sample order
  task automatic drive(input bit rst, input bit c, input bit v,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit cin, input bit sub, input bit en, input bit clr);
    longint unsigned z;
    longint unsigned r;
    longint unsigned mask49;
    exp_t e;
    @(negedge clk);
    #1;
    rstp = rst;
    ce = c;
    bus.in_valid = v;
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
    bus.add_subb = sub;
    bus.acc_en = en;
    bus.acc_clr = clr;
    mask49 = (64'd1 << (W + 1)) - 64'd1;
    if (rst) begin
      q.delete();
      model_p = '0;
    end else if (c) begin
      if (clr) z = 0;
      else if (en) z = {16'd0, model_p};
      else z = {16'd0, b};
      if (sub) r = (z - {16'd0, a} - {63'd0, cin}) & mask49;
      else r = (z + {16'd0, a} + {63'd0, cin}) & mask49;
      if (v) begin
        model_p = r[W-1:0];
        e.p = r[W-1:0];
        e.cout = r[W];
        e.cnt = ce_cnt + 2;
        q.push_back(e);
        $display("in  a=%012h b=%012h cin=%0b sub=%0b en=%0b clr=%0b", a, b, cin, sub, en, clr);
      end else if (clr) begin
        model_p = '0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 1, 0, '0, '0, 0, 0, 0, 0);
  endtask

  function automatic logic [W-1:0] rnd48();
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return {1'b0, {(W-1){1'b1}}};
      3: return {1'b1, {(W-1){1'b0}}};
      default: return v[W-1:0];
    endcase
  endfunction

  initial begin
    rstp = 1'b1;
    ce = 1'b1;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.add_subb = 1'b0;
    bus.acc_en = 1'b0;
    bus.acc_clr = 1'b0;
    drive(1, 1, 0, '0, '0, 0, 0, 0, 0);
    drive(1, 1, 0, '0, '0, 0, 0, 0, 0);
    idle(2);

    // basic add, borrow, carry
    drive(0, 1, 1, 48'd5, 48'd7, 1, 0, 0, 0);
    idle(3);
    drive(0, 1, 1, 48'd1, 48'd0, 0, 1, 0, 0);
    drive(0, 1, 1, 48'hFFFF_FFFF_FFFF, 48'd1, 0, 0, 0, 0);
    idle(3);

    // accumulate burst 10,20,30,40
    drive(0, 1, 1, 48'd10, 48'd0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 1, 1, 48'd10, 48'd0, 0, 0, 1, 0);
    idle(3);

    // same burst with a two-cycle CE stall in the middle
    drive(0, 1, 1, 48'd10, 48'd0, 0, 0, 0, 1);
    drive(0, 1, 1, 48'd10, 48'd0, 0, 0, 1, 0);
    drive(0, 0, 1, 48'd10, 48'd0, 0, 0, 1, 0);
    drive(0, 0, 1, 48'd10, 48'd0, 0, 0, 1, 0);
    drive(0, 1, 1, 48'd10, 48'd0, 0, 0, 1, 0);
    drive(0, 1, 1, 48'd10, 48'd0, 0, 0, 1, 0);
    idle(3);

    // reset mid-burst, then a fresh sample
    drive(0, 1, 1, 48'd10, 48'd0, 0, 0, 0, 1);
    drive(0, 1, 1, 48'd10, 48'd0, 0, 0, 1, 0);
    drive(0, 1, 1, 48'd10, 48'd0, 0, 0, 1, 0);
    drive(1, 1, 1, 48'd10, 48'd0, 0, 0, 1, 0);
    idle(3);
    drive(0, 1, 1, 48'd3, 48'd4, 0, 0, 0, 0);
    idle(3);

    // randomized traffic with stalls, clears, feedback and occasional resets
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 85),
            ($urandom_range(0, 99) < 70), rnd48(), rnd48(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 15));
    end
    idle(6);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
